receiver: RTL and testbench
===========================

# receiver

UART receive engine, the counterpart of the team's UART transmitter. It recovers asynchronous 8N1-style frames (1 start bit, DATA_LENGTH data bits LSB first, 1 stop bit) from the serial `rx` line, using the shared 16x-oversampling `baud_timer` tick. It presents each completed byte to the host side with a single-cycle valid strobe. It sits between the pad and the UART host/FIFO logic, and is clocked from the same `clk` and baud generator as the transmitter.

## Interface
- `DATA_LENGTH`, default 8: data bits per frame; legal range 5–9.
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `baud_timer` input 1: one-`clk`-wide tick at 16x the baud rate.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `rx_data` output DATA_LENGTH: last correctly framed word; held until the next good frame.
- `rx_valid` output 1: one-cycle pulse; `rx_data` is new this cycle.
- `rx_frame_err` output 1: one-cycle pulse; stop bit sampled low, frame discarded.
- `rx_busy` output 1: high in every state except idle.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchronizer (both flops reset to 1) and then one history flop for edge detection.
  - Start is recognized only on a synchronized falling edge (history = 1, current = 0).
  - A line held low after a framing error or a break therefore never retriggers reception.
- Four states: idle, start, data, stop. Any unused encoding returns to idle. One 4-bit oversample counter and one bit counter of width $clog2(DATA_LENGTH).
- idle: counters are 0. A falling edge moves the block to start.
- start: the counter increments on each tick. On the tick where the counter equals 7 (mid start bit):
  - If synced `rx` is 0: clear the counter and bit index, go to data.
  - If synced `rx` is 1: this is a glitch. Return to idle with no output pulse.
- data: the counter increments on each tick. On the tick where the counter equals 15 (mid data bit):
  - Shift synced `rx` into the MSB of the shift register (right shift, so the first-received bit ends at bit 0). Clear the counter.
  - If the bit index equals DATA_LENGTH-1, go to stop. Otherwise increment the bit index.
- stop: on the tick where the counter equals 15, return to idle.
  - If synced `rx` is 1: `rx_data` takes the shift register value and `rx_valid` pulses.
  - If synced `rx` is 0: `rx_frame_err` pulses and `rx_data` is unchanged.
- Counters advance only on `baud_timer` cycles. Cycles without a tick hold all state.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- There is no downstream backpressure. The consumer must take `rx_data` by the next `rx_valid`; there is no overrun flag.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0, state = idle, synchronizer and history flops = 1, shift register = 0.
- Reset asserted mid-frame aborts the frame immediately, with no pulse. After release, a new frame requires a fresh falling edge.
- Edge-to-detect latency: 2 `clk` cycles of synchronizer delay, plus 1 cycle into start. `rx_busy` rises in that same cycle.
- Sample point: 8 ticks after detection for the start bit, then every 16 ticks. The stop bit is sampled 8 + 16·(DATA_LENGTH+1) ticks after detection: 152 ticks for DATA_LENGTH = 8.
- `rx_valid` / `rx_frame_err` are registered. They go high in the `clk` cycle after the stop-sampling tick, and `rx_busy` falls in that same cycle.
- Back-to-back frames: a start edge arriving right after the stop sample (half a stop bit early) is accepted, because idle is re-entered before the next falling edge can be synchronized.
- Tolerated baud mismatch: ±4% cumulative, inherent to mid-bit sampling at 16x.

## Structure
- Shared package/header `uart_defs` holds:
  - the state encodings (idle = 2'h0, start = 2'h1, data = 2'h2, stop = 2'h3), common to both transmitter and receiver;
  - OVERSAMPLE = 16, MID_SAMPLE = 7, LAST_SAMPLE = 15.
- One sub-module, `rx_sync`: the 2-flop synchronizer plus history flop. Outputs are the synced level and a fall pulse. Reset value 1.
- The FSM, counters and output registers stay in `receiver`.

## Test plan
- Loopback with the team transmitter (DATA_LENGTH 8), sending 0x55, 0xA3, 0x00, 0xFF back-to-back -> four `rx_valid` pulses, `rx_data` equal to each byte in order, no `rx_frame_err`.
- Low glitch on `rx` lasting 5 ticks from idle -> returns to idle at tick 7, no pulse on either output, `rx_busy` high for about 7 ticks.
- Frame 0x3C with the stop bit forced low -> one `rx_frame_err` pulse, `rx_data` keeps its previous value, and no new frame starts until `rx` goes high and falls again.
- Reset asserted at data bit 4 of 0x81 -> all outputs at reset values within the reset cycle. The next good frame 0x7E is received correctly.
- Transmit stimulus at +3% and −3% bit period with 0xC5 -> received correctly both times.
- Line held low for 40 bit times (break) -> exactly one `rx_frame_err`, then silence until a rising edge followed by a new start edge.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings common to the transmitter and
// receiver, plus the 16x oversampling constants.
package uart_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'h0,
        ST_START = 2'h1,
        ST_DATA  = 2'h2,
        ST_STOP  = 2'h3
    } uart_state_e;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned MID_SAMPLE  = 7;
    localparam int unsigned LAST_SAMPLE = 15;

endpackage : uart_defs

// File: rtl/rx_sync.sv
// Input conditioning for the asynchronous serial line: 2-flop synchronizer
// followed by a history flop for falling-edge detection.
//   clk, reset_n : clock, async active-low reset (all flops reset to 1 = idle line)
//   i_rx         : raw serial input, asynchronous to clk
//   o_rx_sync    : synchronized line level (registered)
//   o_fall_c     : combinational one-cycle pulse on a synchronized 1->0 transition
module rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Synchronizer chain plus history; resetting to 1 means no spurious edge at reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_rx_sync = r_sync;
    // Only a genuine high-to-low transition starts a frame; a line stuck low never retriggers.
    assign o_fall_c  = r_hist & ~r_sync;

endmodule : rx_sync

// File: rtl/receiver.sv
// UART receive engine: recovers start/data/stop frames (data LSB first) from
// the serial line using the shared 16x baud tick, sampling at mid-bit.
//   clk, reset_n     : clock, async active-low reset
//   i_baud_timer     : one-clk tick at 16x the baud rate
//   i_rx             : serial line, idles high
//   o_rx_data        : last correctly framed word, held until the next good frame
//   o_rx_valid       : one-cycle pulse, o_rx_data is new
//   o_rx_frame_err   : one-cycle pulse, stop bit sampled low and frame discarded
//   o_rx_busy        : high whenever the receiver is not idle
module receiver
    import uart_defs::*;
#(
    parameter int unsigned DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_baud_timer,
    input  logic                   i_rx,
    output logic [DATA_LENGTH-1:0] o_rx_data,
    output logic                   o_rx_valid,
    output logic                   o_rx_frame_err,
    output logic                   o_rx_busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_LENGTH);

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(MID_SAMPLE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_SAMPLE);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LENGTH - 1);

    logic w_rx_sync;
    logic w_fall;

    uart_state_e            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit_idx;
    logic [DATA_LENGTH-1:0] r_shift;
    logic [DATA_LENGTH-1:0] r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_busy;

    uart_state_e            w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [BIT_W-1:0]       w_bit_idx_nxt;
    logic [DATA_LENGTH-1:0] w_shift_nxt;
    logic [DATA_LENGTH-1:0] w_data_nxt;
    logic                   w_valid_nxt;
    logic                   w_frame_err_nxt;
    logic                   w_busy_nxt;

    rx_sync u_rx_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_rx      (i_rx),
        .o_rx_sync (w_rx_sync),
        .o_fall_c  (w_fall)
    );

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic; everything holds between baud ticks.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (i_baud_timer) begin
                    if (r_cnt == MID_CNT) begin
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = '0;
                        // Line back high at mid start bit: treat as a glitch.
                        w_state_nxt   = w_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (i_baud_timer) begin
                    if (r_cnt == LAST_CNT) begin
                        w_cnt_nxt   = '0;
                        // Right shift so the first bit received lands in bit 0.
                        w_shift_nxt = {w_rx_sync, r_shift[DATA_LENGTH-1:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (i_baud_timer) begin
                    if (r_cnt == LAST_CNT) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                        if (w_rx_sync) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_frame_err_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign o_rx_data      = r_data;
    assign o_rx_valid     = r_valid;
    assign o_rx_frame_err = r_frame_err;
    assign o_rx_busy      = r_busy;

endmodule : receiver

// File: tb/tb_receiver.sv
// Directed self-checking bench for the UART receiver (DATA_LENGTH = 8).
module tb_receiver;

    localparam int unsigned DL       = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int          BIT_CLKS = 16 * TICK_DIV;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          baud_timer = 1'b0;
    logic          rx         = 1'b1;
    logic [DL-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_busy;

    int total = 0;
    int bad   = 0;

    // Monitor state: only written by the monitor process.
    logic [DL-1:0] rxq[$];
    int            err_cnt  = 0;
    int            both_cnt = 0;
    int            busy_cnt = 0;

    logic [DL-1:0] exp_data;

    receiver #(.DATA_LENGTH(DL)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_baud_timer   (baud_timer),
        .i_rx           (rx),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .o_rx_frame_err (rx_frame_err),
        .o_rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk wide every TICK_DIV clks, driven on the falling edge.
    initial begin
        int div_cnt;
        div_cnt = 0;
        forever begin
            @(negedge clk);
            baud_timer = (div_cnt == TICK_DIV - 1);
            div_cnt    = (div_cnt + 1) % TICK_DIV;
        end
    end

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (rx_frame_err) err_cnt = err_cnt + 1;
        if (rx_valid && rx_frame_err) both_cnt = both_cnt + 1;
        if (rx_busy) busy_cnt = busy_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DL-1:0] d, input int bit_clks, input logic stop_bit);
        rx = 1'b0;
        wait_clks(bit_clks);
        for (int i = 0; i < int'(DL); i++) begin
            rx = d[i];
            wait_clks(bit_clks);
        end
        rx = stop_bit;
        wait_clks(bit_clks);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        wait_clks(5);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rx_frame_err); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        reset_n = 1'b1;
        wait_clks(BIT_CLKS);
        exp_data = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [DL-1:0] bytes [4];
        logic [DL-1:0] got;
        int            q0, e0, b0;
        bytes[0] = 8'h55; bytes[1] = 8'hA3; bytes[2] = 8'h00; bytes[3] = 8'hFF;
        q0 = rxq.size(); e0 = err_cnt; b0 = both_cnt;
        for (int i = 0; i < 4; i++) send_frame(bytes[i], BIT_CLKS, 1'b1);
        wait_clks(2 * BIT_CLKS);
        total++; if (rxq.size() - q0 !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", rxq.size() - q0); end
        for (int i = 0; i < 4; i++) begin
            got = (q0 + i < rxq.size()) ? rxq[q0 + i] : 8'hxx;
            total++; if (got !== bytes[i]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got, bytes[i]); end
        end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0); end
        total++; if (both_cnt - b0 !== 0) begin bad++; $display("FAIL b2b_both got=%0d exp=0", both_cnt - b0); end
        total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL b2b_hold got=%h exp=ff", rx_data); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", rx_busy); end
        exp_data = 8'hFF;
    endtask

    task automatic test_glitch();
        int q0, e0, bc0, busy_len;
        q0 = rxq.size(); e0 = err_cnt; bc0 = busy_cnt;
        rx = 1'b0;
        wait_clks(5 * TICK_DIV);
        rx = 1'b1;
        wait_clks(200);
        busy_len = busy_cnt - bc0;
        total++; if (rxq.size() - q0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", rxq.size() - q0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - e0); end
        total++; if (busy_len < 28 || busy_len > 34) begin bad++; $display("FAIL glitch_busy_len got=%0d exp=28..34", busy_len); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", rx_busy); end
    endtask

    task automatic test_frame_err();
        int q0, e0;
        q0 = rxq.size(); e0 = err_cnt;
        send_frame(8'h3C, BIT_CLKS, 1'b0);
        wait_clks(3 * BIT_CLKS);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", err_cnt - e0); end
        total++; if (rxq.size() - q0 !== 0) begin bad++; $display("FAIL ferr_valid got=%0d exp=0", rxq.size() - q0); end
        total++; if (rx_data !== exp_data) begin bad++; $display("FAIL ferr_hold got=%h exp=%h", rx_data, exp_data); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_no_retrigger got=%b exp=0", rx_busy); end
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_after got=%0d exp=1", err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [DL-1:0] d;
        logic [DL-1:0] got;
        int            q0, e0;
        d  = 8'h81;
        q0 = rxq.size(); e0 = err_cnt;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = d[4];
        wait_clks(BIT_CLKS / 2);
        reset_n = 1'b0;
        #1;
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", rx_busy); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", rx_data); end
        total++; if ({rx_valid, rx_frame_err} !== 2'b00) begin bad++; $display("FAIL rstmid_pulses got=%b exp=00", {rx_valid, rx_frame_err}); end
        rx = 1'b1;
        wait_clks(4);
        reset_n = 1'b1;
        wait_clks(2 * BIT_CLKS);
        total++; if (rxq.size() - q0 !== 0) begin bad++; $display("FAIL rstmid_nopulse got=%0d exp=0", rxq.size() - q0); end
        send_frame(8'h7E, BIT_CLKS, 1'b1);
        wait_clks(BIT_CLKS);
        got = (rxq.size() > q0) ? rxq[rxq.size() - 1] : 8'hxx;
        total++; if (rxq.size() - q0 !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", rxq.size() - q0); end
        total++; if (got !== 8'h7E) begin bad++; $display("FAIL rstmid_next got=%h exp=7e", got); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL rstmid_err got=%0d exp=0", err_cnt - e0); end
        exp_data = 8'h7E;
    endtask

    task automatic test_baud_mismatch();
        int            periods [2];
        logic [DL-1:0] got;
        int            q0, e0;
        periods[0] = BIT_CLKS + 2;
        periods[1] = BIT_CLKS - 2;
        for (int p = 0; p < 2; p++) begin
            q0 = rxq.size(); e0 = err_cnt;
            send_frame(8'hC5, periods[p], 1'b1);
            wait_clks(2 * BIT_CLKS);
            got = (rxq.size() > q0) ? rxq[rxq.size() - 1] : 8'hxx;
            total++; if (rxq.size() - q0 !== 1) begin bad++; $display("FAIL baud%0d_count got=%0d exp=1", periods[p], rxq.size() - q0); end
            total++; if (got !== 8'hC5) begin bad++; $display("FAIL baud%0d_data got=%h exp=c5", periods[p], got); end
            total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL baud%0d_err got=%0d exp=0", periods[p], err_cnt - e0); end
        end
        exp_data = 8'hC5;
    endtask

    task automatic test_break();
        logic [DL-1:0] got;
        int            q0, e0;
        q0 = rxq.size(); e0 = err_cnt;
        rx = 1'b0;
        wait_clks(40 * BIT_CLKS);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL break_err got=%0d exp=1", err_cnt - e0); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL break_busy got=%b exp=0", rx_busy); end
        total++; if (rx_data !== exp_data) begin bad++; $display("FAIL break_hold got=%h exp=%h", rx_data, exp_data); end
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        send_frame(8'h5A, BIT_CLKS, 1'b1);
        wait_clks(BIT_CLKS);
        got = (rxq.size() > q0) ? rxq[rxq.size() - 1] : 8'hxx;
        total++; if (rxq.size() - q0 !== 1) begin bad++; $display("FAIL break_count got=%0d exp=1", rxq.size() - q0); end
        total++; if (got !== 8'h5A) begin bad++; $display("FAIL break_next got=%h exp=5a", got); end
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL break_err_total got=%0d exp=1", err_cnt - e0); end
    endtask

    initial begin
        exp_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_baud_mismatch();
        test_break();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_receiver
